// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, NOP encoding, PC step, fetch states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned INSTR_W_DEF = 32;

  // All-zero word is the pipeline bubble placed in IF/ID on a flush.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Sequential fetch advances by one 32-bit instruction.
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: redirect to a target, step by PC_STEP, or hold.
// Latency: new PC visible one cycle after redirect_i/incr_i.
// Backpressure: holds whenever neither redirect_i nor incr_i is asserted.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (loads RESET_PC)
//   redirect_i        load target_i; wins over incr_i
//   target_i          redirect address
//   incr_i            advance by PC_STEP, wrapping modulo 2^ADDR_W
//   pc_o              current PC
module pc_reg
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = target_i;
    end else if (incr_i) begin
      // Natural overflow of the ADDR_W-bit add gives the required wrap.
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one imem request at a time and fills the IF/ID register.
// Latency: request one cycle after IDLE/delivery; IF/ID loads the cycle after the data beat.
// Backpressure: stall_i freezes IF/ID and PC; a beat returning under stall parks in a 1-entry buffer.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   pc_select_i           redirect PC to branch_target_i (always accepted)
//   branch_target_i       redirect address
//   clear_pipes_i         flush IF/ID to a NOP bubble (wins over stall and load)
//   stall_i               hold IF/ID and PC
//   imem_req_o/addr_o     single-cycle fetch request and its address
//   imem_valid_i/data_i   fetch response, at least one cycle after the request
//   instr_o/pc_o/valid_o  IF/ID register
//   redirect_cnt_o        saturating count of redirect cycles (only with FETCH_REDIRECT_CNT_EN)
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pc_select_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic               clear_pipes_i,
  input  logic               stall_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_valid_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [15:0]        redirect_cnt_o
`endif
);

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic               req_q;
  logic [ADDR_W-1:0]  pc;
  logic               pc_incr;
  logic               deliver_mem;
  logic               deliver_buf;
  logic               buf_capture;
  logic [INSTR_W-1:0] hold_buf_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_id_q;
  logic               valid_q;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .redirect_i (pc_select_i),
    .target_i   (branch_target_i),
    .incr_i     (pc_incr),
    .pc_o       (pc)
  );

  // Next-state and datapath decode. imem_valid_i is only looked at in WAIT
  // and DISCARD, which are exactly the states with a request outstanding.
  always_comb begin
    state_d     = state_q;
    pc_incr     = 1'b0;
    deliver_mem = 1'b0;
    deliver_buf = 1'b0;
    buf_capture = 1'b0;
    case (state_q)
      IDLE:    state_d = ISSUE;
      // The request goes out this cycle regardless; a redirect now means its
      // beat belongs to the old path and must be thrown away.
      ISSUE:   state_d = pc_select_i ? DISCARD : WAIT;
      WAIT: begin
        if (pc_select_i) begin
          state_d = imem_valid_i ? ISSUE : DISCARD;
        end else if (imem_valid_i) begin
          if (stall_i) begin
            buf_capture = 1'b1;
            state_d     = HOLD;
          end else begin
            deliver_mem = 1'b1;
            pc_incr     = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      HOLD: begin
        if (pc_select_i) begin
          state_d = ISSUE;
        end else if (!stall_i) begin
          deliver_buf = 1'b1;
          pc_incr     = 1'b1;
          state_d     = ISSUE;
        end
      end
      DISCARD: begin
        if (imem_valid_i) begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == ISSUE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_buf_q <= '0;
    end else if (buf_capture) begin
      hold_buf_q <= imem_data_i;
    end
  end

  // IF/ID register. Flush beats everything; otherwise an unstalled cycle
  // with nothing new to hand over becomes a bubble so ID never sees a repeat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= '0;
      pc_id_q <= '0;
      valid_q <= 1'b0;
    end else if (clear_pipes_i) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (deliver_mem || deliver_buf) begin
      instr_q <= deliver_buf ? hold_buf_q : imem_data_i;
      pc_id_q <= pc;
      valid_q <= 1'b1;
    end else if (!stall_i) begin
      valid_q <= 1'b0;
    end
  end

`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirect_cnt_q <= '0;
    end else if (pc_select_i && (redirect_cnt_q != 16'hFFFF)) begin
      redirect_cnt_q <= redirect_cnt_q + 16'd1;
    end
  end

  assign redirect_cnt_o = redirect_cnt_q;
`endif

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc;
  assign instr_o     = instr_q;
  assign pc_o        = pc_id_q;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios then randomized traffic, checked against a transaction-level model.
// Latency: n/a (simulation only).
// Backpressure: memory responder answers 1-3 cycles after each request; stall/redirect/flush driven randomly.
module tb_fetch_unit;

  localparam logic [31:0] HI_RESET = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, clr, stall, mv;
  logic [31:0] tgt, md;
  logic        req_lo, req_hi, val_lo, val_hi;
  logic [31:0] addr_lo, addr_hi, ins_lo, ins_hi, pco_lo, pco_hi;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [15:0] cnt_lo, cnt_hi;
`endif

  fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) u_dut (
    .clk_i(clk), .rst_i(rst), .pc_select_i(sel), .branch_target_i(tgt),
    .clear_pipes_i(clr), .stall_i(stall), .imem_req_o(req_lo), .imem_addr_o(addr_lo),
    .imem_valid_i(mv), .imem_data_i(md), .instr_o(ins_lo), .pc_o(pco_lo), .valid_o(val_lo)
`ifdef FETCH_REDIRECT_CNT_EN
    , .redirect_cnt_o(cnt_lo)
`endif
  );

  // Second copy in lockstep, started near the top of the address space.
  fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(HI_RESET)) u_dut_hi (
    .clk_i(clk), .rst_i(rst), .pc_select_i(sel), .branch_target_i(tgt),
    .clear_pipes_i(clr), .stall_i(stall), .imem_req_o(req_hi), .imem_addr_o(addr_hi),
    .imem_valid_i(mv), .imem_data_i(md), .instr_o(ins_hi), .pc_o(pco_hi), .valid_o(val_hi)
`ifdef FETCH_REDIRECT_CNT_EN
    , .redirect_cnt_o(cnt_hi)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transaction-level model: who owns the next memory beat, what is parked,
  // and what ID should be looking at.
  bit          m_known = 1'b0;
  bit          m_boot, m_req, m_busy, m_drop, m_held, m_valid;
  logic [31:0] m_pc_lo, m_pc_hi, m_hinstr, m_instr, m_pco, m_pco_hi;
  logic [15:0] m_cnt;

  int          mem_cnt = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_addr_hi[$];
  logic [31:0] q_pco[$];

  task automatic model_step();
    bit          deliver;
    bit          nreq;
    logic [31:0] di;
    if (rst) begin
      m_known = 1'b1;
      m_pc_lo = 32'h0;  m_pc_hi = HI_RESET;
      m_boot  = 1'b1;   m_req   = 1'b0;  m_busy = 1'b0;  m_drop = 1'b0;  m_held = 1'b0;
      m_valid = 1'b0;   m_instr = 32'h0; m_pco  = 32'h0; m_pco_hi = 32'h0; m_cnt = 16'h0;
    end else begin
      deliver = 1'b0;
      nreq    = 1'b0;
      di      = 32'h0;
      if (m_boot) begin
        m_boot = 1'b0;
        nreq   = 1'b1;
      end else if (m_req) begin
        m_busy = 1'b1;
        m_drop = sel;
      end else if (m_busy) begin
        if (mv) begin
          m_busy = 1'b0;
          if (m_drop || sel) begin
            m_drop = 1'b0;
            nreq   = 1'b1;
          end else if (stall) begin
            m_held   = 1'b1;
            m_hinstr = md;
          end else begin
            deliver = 1'b1;
            di      = md;
            nreq    = 1'b1;
          end
        end else if (sel) begin
          m_drop = 1'b1;
        end
      end else if (m_held) begin
        if (sel) begin
          m_held = 1'b0;
          nreq   = 1'b1;
        end else if (!stall) begin
          m_held  = 1'b0;
          deliver = 1'b1;
          di      = m_hinstr;
          nreq    = 1'b1;
        end
      end
      if (clr) begin
        m_valid = 1'b0;
        m_instr = 32'h0;
      end else if (deliver) begin
        m_valid  = 1'b1;
        m_instr  = di;
        m_pco    = m_pc_lo;
        m_pco_hi = m_pc_hi;
      end else if (!stall) begin
        m_valid = 1'b0;
      end
      if (sel) begin
        m_pc_lo = tgt;
        m_pc_hi = tgt;
      end else if (deliver) begin
        m_pc_lo = m_pc_lo + 32'd4;
        m_pc_hi = m_pc_hi + 32'd4;
      end
      if (sel && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_req = nreq;
    end
  endtask

  // One clock cycle: check what the DUT shows, then drive this cycle's inputs.
  task automatic cyc(input bit r, input bit s, input logic [31:0] t, input bit c,
                     input bit st, input int lat, input bit spur);
    @(negedge clk);
    if (m_known) begin
      chk_eq("req", req_lo, m_req);
      chk_eq("req_hi", req_hi, m_req);
      if (m_req) begin
        chk_eq("addr", addr_lo, m_pc_lo);
        chk_eq("addr_hi", addr_hi, m_pc_hi);
      end
      chk_eq("valid", val_lo, m_valid);
      chk_eq("instr", ins_lo, m_instr);
      chk_eq("pc_o", pco_lo, m_pco);
      chk_eq("valid_hi", val_hi, m_valid);
      chk_eq("instr_hi", ins_hi, m_instr);
      chk_eq("pc_o_hi", pco_hi, m_pco_hi);
`ifdef FETCH_REDIRECT_CNT_EN
      chk_eq("redir_cnt", {16'h0, cnt_lo}, {16'h0, m_cnt});
`endif
    end
    if (req_lo) q_addr.push_back(addr_lo);
    if (req_hi) q_addr_hi.push_back(addr_hi);
    if (val_lo) q_pco.push_back(pco_lo);
    rst = r; sel = s; tgt = t; clr = c; stall = st; md = $urandom; mv = 1'b0;
    if (mem_cnt == 1) begin
      mv      = 1'b1;
      mem_cnt = 0;
    end else if (mem_cnt > 1) begin
      mem_cnt--;
    end else if (spur && !r) begin
      mv = 1'b1;  // unsolicited beat while nothing is outstanding
    end
    // A request caught by reset still gets its (late) beat next cycle.
    if (r) begin
      if (mem_cnt != 0 || req_lo) mem_cnt = 1;
    end else if (req_lo) begin
      mem_cnt = lat;
    end
    model_step();
  endtask

  task automatic idle(input int lat);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, lat, 1'b0);
  endtask

  task automatic wait_issue(input int lat);
    for (int k = 0; k < 20 && !m_req; k++) idle(lat);
    if (!m_req) chk_eq("issue_timeout", {31'h0, m_req}, 32'h1);
  endtask

  int          sz;
  bit          r_r, r_s, r_c, r_st, r_sp;
  logic [31:0] r_t;

  initial begin
    rst = 1'b1; sel = 1'b0; tgt = 32'h0; clr = 1'b0; stall = 1'b0; mv = 1'b0; md = 32'h0;

    // Reset release with a one-cycle memory: 0x0, 0x4, 0x8 in order.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1, 1'b0);
    q_addr.delete(); q_addr_hi.delete(); q_pco.delete();
    repeat (9) idle(1);
    chk_eq("boot_nreq", {31'h0, q_addr.size() >= 3}, 32'h1);
    chk_eq("boot_npc", {31'h0, q_pco.size() >= 3}, 32'h1);
    if (q_addr.size() >= 3 && q_pco.size() >= 3) begin
      chk_eq("boot_addr1", q_addr[1], 32'h4);
      chk_eq("boot_addr2", q_addr[2], 32'h8);
      chk_eq("boot_pc0", q_pco[0], 32'h0);
      chk_eq("boot_pc1", q_pco[1], 32'h4);
      chk_eq("boot_pc2", q_pco[2], 32'h8);
    end
    chk_eq("wrap_nreq", {31'h0, q_addr_hi.size() >= 2}, 32'h1);
    if (q_addr_hi.size() >= 2) begin
      chk_eq("wrap_addr0", q_addr_hi[0], HI_RESET);
      chk_eq("wrap_addr1", q_addr_hi[1], 32'h0);
    end

    // Stall for three cycles while the beat returns: parked, no new request.
    wait_issue(1);
    idle(1);
    sz = q_addr.size();
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1, 1'b0);
    idle(1);
    chk_eq("hold_noreq", sz, q_addr.size());
    repeat (3) idle(1);

    // Redirect to 0x100 while waiting: old beat dropped, fetch resumes at target.
    wait_issue(1);
    idle(3);
    cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 3, 1'b0);
    q_addr.delete(); q_pco.delete();
    repeat (10) idle(1);
    chk_eq("redir_n", {31'h0, q_addr.size() >= 1 && q_pco.size() >= 1}, 32'h1);
    if (q_addr.size() >= 1 && q_pco.size() >= 1) begin
      chk_eq("redir_addr", q_addr[0], 32'h100);
      chk_eq("redir_pc", q_pco[0], 32'h100);
    end

    // Flush coincident with stall and a returning beat.
    wait_issue(1);
    idle(1);
    idle(1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
    @(posedge clk); #1;
    chk_eq("clr_valid", {31'h0, val_lo}, 32'h0);
    chk_eq("clr_instr", ins_lo, 32'h0);
    repeat (4) idle(1);

    // Reset in the middle of a request.
    wait_issue(3);
    idle(3);
    idle(3);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3, 1'b0);
    @(posedge clk); #1;
    chk_eq("rst_req", {31'h0, req_lo}, 32'h0);
    chk_eq("rst_valid", {31'h0, val_lo}, 32'h0);
    chk_eq("rst_pc_o", pco_lo, 32'h0);
    q_addr.delete(); q_addr_hi.delete();
    repeat (6) idle(1);
    chk_eq("rst_nreq", {31'h0, q_addr.size() >= 1 && q_addr_hi.size() >= 1}, 32'h1);
    if (q_addr.size() >= 1 && q_addr_hi.size() >= 1) begin
      chk_eq("rst_addr", q_addr[0], 32'h0);
      chk_eq("rst_addr_hi", q_addr_hi[0], HI_RESET);
    end

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r_r  = ($urandom_range(0, 99) == 0);
      r_s  = ($urandom_range(0, 9) == 0);
      r_c  = ($urandom_range(0, 9) == 0);
      r_st = ($urandom_range(0, 9) < 3);
      r_sp = ($urandom_range(0, 7) == 0);
      r_t  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      cyc(r_r, r_s, r_t, r_c, r_st, $urandom_range(1, 3), r_sp);
    end
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
